// File: rtl/mc_seq_regs.sv
// Multicycle MIPS datapath sequencing registers: PC, instruction register,
// non-architectural pipeline latches, misalignment flag and fetch counter.
module mc_seq_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pcWrite,
    input  logic        branch,
    input  logic        IRWrite,
    input  logic        iord,
    input  logic [1:0]  pcsrc,
    input  logic        zero,
    input  logic [31:0] aluresult,
    input  logic [31:0] readdata,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic [31:0] pc,
    output logic [31:0] adr,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] aluout,
    output logic        misalign,
    output logic [31:0] instcount
);

    logic        pcen;
    logic [31:0] pcnext;

    assign pcen = pcWrite | (branch & zero);

    // Jump target uses the registered pc/instr, so a same-cycle IRWrite cannot alter it.
    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pcnext = pc;
        unique case (pcsrc)
            2'b00: pcnext = aluresult;
            2'b01: pcnext = aluout;
            2'b10: pcnext = {pc[31:28], instr[25:0], 2'b00};
            2'b11: pcnext = pc;
        endcase
    end

    assign adr   = iord ? aluout : pc;
    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            instr     <= '0;
            data      <= '0;
            a         <= '0;
            b         <= '0;
            aluout    <= '0;
            misalign  <= 1'b0;
            instcount <= '0;
        end else begin
            data   <= readdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
            if (pcen) begin
                pc <= pcnext;
                if (pcnext[1:0] != 2'b00) misalign <= 1'b1;
            end
            if (IRWrite) begin
                instr     <= readdata;
                instcount <= instcount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mc_seq_regs.sv
// Directed table-driven bench for mc_seq_regs plus hand-written reset and wrap sequences.
module tb_mc_seq_regs;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pcWrite, branch, IRWrite, iord, zero;
    logic [1:0]  pcsrc;
    logic [31:0] aluresult, readdata, rd1, rd2;
    logic [31:0] pc, adr, instr, data, a, b, aluout, instcount;
    logic [5:0]  op, funct;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    mc_seq_regs #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .pcWrite(pcWrite), .branch(branch),
        .IRWrite(IRWrite), .iord(iord), .pcsrc(pcsrc), .zero(zero),
        .aluresult(aluresult), .readdata(readdata), .rd1(rd1), .rd2(rd2),
        .pc(pc), .adr(adr), .instr(instr), .op(op), .funct(funct),
        .data(data), .a(a), .b(b), .aluout(aluout), .misalign(misalign),
        .instcount(instcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw, br, ir, io;
        logic [1:0]  src;
        logic        z;
        logic [31:0] alu, rdat, r1, r2;
        logic [31:0] e_pc, e_instr, e_cnt;
        logic        e_mis;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic br, input logic ir, input logic io,
                         input logic [1:0] src, input logic z, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [31:0] r1, input logic [31:0] r2);
        pcWrite = pw; branch = br; IRWrite = ir; iord = io; pcsrc = src; zero = z;
        aluresult = alu; readdata = rdat; rd1 = r1; rd2 = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        //           pw    br    ir    io    src    z     alu            rdat           r1     r2     e_pc           e_instr        e_cnt  e_mis
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h4,         32'h8C01_0004, 32'h11, 32'h22, 32'h4,         32'h8C01_0004, 32'd1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40,        32'h1234,      32'h33, 32'h44, 32'h4,         32'h8C01_0004, 32'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h40,        32'h0,         32'h55, 32'h66, 32'h4,         32'h8C01_0004, 32'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h40,        32'h0,         32'h77, 32'h88, 32'h40,        32'h8C01_0004, 32'd1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h80,        32'hA5A5,      32'h1,  32'h2,  32'h80,        32'h8C01_0004, 32'd1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 32'h44,        32'h5A5A,      32'h3,  32'h4,  32'h80,        32'h8C01_0004, 32'd1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1000_0010, 32'h0800_0100, 32'h5,  32'h6,  32'h1000_0010, 32'h0800_0100, 32'd2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0,         32'h0BFF_FFFF, 32'h7,  32'h8,  32'h1000_0400, 32'h0BFF_FFFF, 32'd3, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h6,         32'h0,         32'h9,  32'hA,  32'h6,         32'h0BFF_FFFF, 32'd3, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h8,         32'h0,         32'hB,  32'hC,  32'h8,         32'h0BFF_FFFF, 32'd3, 1'b1};

        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0, '0);
        #12;
        check("reset_pc", pc, RST_PC);
        check("reset_instr", instr, 32'h0);
        check("reset_op", {26'h0, op}, 32'h0);
        check("reset_aluout", aluout, 32'h0);
        check("reset_misalign", {31'h0, misalign}, 32'h0);
        check("reset_instcount", instcount, 32'h0);
        check("reset_adr", adr, RST_PC);

        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].pw, vecs[i].br, vecs[i].ir, vecs[i].io, vecs[i].src, vecs[i].z,
                  vecs[i].alu, vecs[i].rdat, vecs[i].r1, vecs[i].r2);
            tick();
            check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
            check($sformatf("v%0d_op", i), {26'h0, op}, {26'h0, vecs[i].e_instr[31:26]});
            check($sformatf("v%0d_funct", i), {26'h0, funct}, {26'h0, vecs[i].e_instr[5:0]});
            check($sformatf("v%0d_data", i), data, vecs[i].rdat);
            check($sformatf("v%0d_a", i), a, vecs[i].r1);
            check($sformatf("v%0d_b", i), b, vecs[i].r2);
            check($sformatf("v%0d_aluout", i), aluout, vecs[i].alu);
            check($sformatf("v%0d_instcount", i), instcount, vecs[i].e_cnt);
            check($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vecs[i].e_mis});
            check($sformatf("v%0d_adr", i), adr, vecs[i].io ? vecs[i].alu : vecs[i].e_pc);
        end

        // Reset asserted mid-cycle with loads pending: clears at once and discards them.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hC, 32'hFFFF, 32'h1, 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_pc", pc, RST_PC);
        check("async_rst_misalign", {31'h0, misalign}, 32'h0);
        check("async_rst_instr", instr, 32'h0);
        tick();
        check("held_rst_pc", pc, RST_PC);
        check("held_rst_instcount", instcount, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("resume_pc", pc, 32'hC);
        check("resume_instr", instr, 32'hFFFF);
        check("resume_instcount", instcount, 32'd1);

        // Misaligned target without pcen must not set the flag; with pcen via aluout it must.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, 32'h0, 32'h0);
        tick();
        check("nopcen_pc", pc, 32'hC);
        check("nopcen_misalign", {31'h0, misalign}, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("src01_pc", pc, 32'h3);
        check("src01_misalign", {31'h0, misalign}, 32'h1);

        // Counter wrap: preload all-ones between edges, then one fetch.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        force dut.instcount = 32'hFFFF_FFFF;
        #1;
        release dut.instcount;
        #1;
        check("preload_instcount", instcount, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick();
        check("wrap_instcount", instcount, 32'h0);
        check("wrap_instr", instr, 32'hDEAD_BEEF);

        // Reset between edges takes effect with no clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("between_edges_pc", pc, RST_PC);
        check("between_edges_misalign", {31'h0, misalign}, 32'h0);
        check("between_edges_instr", instr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_seq_regs.md
MC_SEQ_REGS -- requirements
Module: mc_seq_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port pcWrite, input, 1 bit: unconditional PC write enable from the main control FSM.
REQ-005 SHALL have port branch, input, 1 bit: conditional PC write enable, qualified by zero.
REQ-006 SHALL have port IRWrite, input, 1 bit: instruction register load enable.
REQ-007 SHALL have port iord, input, 1 bit: memory address select; 0 = pc, 1 = aluout.
REQ-008 SHALL have port pcsrc, input, 2 bits: next-PC source select.
REQ-009 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-010 SHALL have port aluresult, input, 32 bits: combinational ALU result.
REQ-011 SHALL have port readdata, input, 32 bits: memory read data.
REQ-012 SHALL have port rd1, input, 32 bits: register file read port 1.
REQ-013 SHALL have port rd2, input, 32 bits: register file read port 2.
REQ-014 SHALL have port pc, output, 32 bits: program counter register.
REQ-015 SHALL have port adr, output, 32 bits: memory address, combinational from iord.
REQ-016 SHALL have port instr, output, 32 bits: instruction register.
REQ-017 SHALL have port op, output, 6 bits: instr[31:26], feeding the main control FSM.
REQ-018 SHALL have port funct, output, 6 bits: instr[5:0].
REQ-019 SHALL have ports data, a, b and aluout, each output, 32 bits: non-architectural registers.
REQ-020 SHALL have port misalign, output, 1 bit: sticky flag for a misaligned PC.
REQ-021 SHALL have port instcount, output, 32 bits: retired-fetch counter.

Function
REQ-022 SHALL compute pcen = pcWrite | (branch & zero); when both pcWrite and branch are high, pcen is 1 regardless of zero.
REQ-023 SHALL select pcnext by pcsrc: 00 = aluresult; 01 = aluout; 10 = {pc[31:28], instr[25:0], 2'b00}; 11 = pc (hold).
REQ-024 SHALL load pc <= pcnext on a clock edge only when pcen = 1; otherwise pc holds.
REQ-025 SHALL form the jump target from the instr and pc register values present before the edge; a same-cycle IRWrite does not affect it.
REQ-026 SHALL drive adr = iord ? aluout : pc combinationally, with no added latency.
REQ-027 SHALL load instr <= readdata when IRWrite = 1; otherwise instr holds.
REQ-028 SHALL drive op and funct as combinational slices of the instr register.
REQ-029 SHALL load data <= readdata, a <= rd1, b <= rd2 and aluout <= aluresult on every clock edge, unconditionally (one-cycle latency).
REQ-030 SHALL set misalign to 1 on any edge where pcen = 1 and pcnext[1:0] != 2'b00.
REQ-031 SHALL keep misalign at 1 until reset once set; the misaligned PC value is still loaded.
REQ-032 SHALL increment instcount by 1 on every edge with IRWrite = 1; at 32'hFFFF_FFFF it wraps to 0 and is not saturated.
REQ-033 SHALL apply IRWrite and pcen in the same cycle independently: instr receives memory data at the old pc while pc updates.

Reset
REQ-034 SHALL, while reset_n = 0 and independent of clk, force pc = RESET_PC, instr = 0, data = a = b = aluout = 0, misalign = 0 and instcount = 0.
REQ-035 SHALL make op and funct read 0 while in reset, as a consequence of instr = 0.
REQ-036 SHALL, on reset asserted mid-operation, discard any pending load that cycle.
REQ-037 SHALL resume normal updates on the first rising clk edge after reset_n returns to 1.

Verification
REQ-038 SHALL cover fetch: reset, then IRWrite = 1, pcWrite = 1, pcsrc = 00, aluresult = 4, readdata = 32'h8C01_0004 -> after one edge instr = 32'h8C01_0004, op = 6'b100011, pc = 4, instcount = 1.
REQ-039 SHALL cover branch: branch = 1, pcWrite = 0, pcsrc = 01, aluout = 32'h40, with zero = 0 -> pc unchanged; then zero = 1 -> pc = 32'h40.
REQ-040 SHALL cover jump: pc = 32'h1000_0010, instr = 32'h0800_0100, pcsrc = 10, pcWrite = 1 -> pc = 32'h1000_0400.
REQ-041 SHALL cover misalignment: pcWrite = 1, pcsrc = 00, aluresult = 32'h6 -> pc = 6, misalign = 1; misalign stays 1 after further aligned writes, and clears only on reset.
REQ-042 SHALL cover wrap and asynchronous reset: instcount = 32'hFFFF_FFFF with IRWrite = 1 -> 0; then reset_n driven low between edges -> pc = RESET_PC immediately, with no clk edge required.
